// File: rtl/ann_pkg.sv
// Shared definitions for the sequential neuron: FSM state encoding and
// flat-bus channel extraction (supports WIDTH <= 64 and N_IN*WIDTH <= 4096).
package ann_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } ann_state_t;

  localparam int unsigned ANN_MAX_W    = 64;
  localparam int unsigned ANN_MAX_CH   = 64;
  localparam int unsigned ANN_MAX_FLAT = ANN_MAX_W * ANN_MAX_CH;

  // Channel idx occupies bits [idx*width +: width]; caller truncates to its width.
  function automatic logic [ANN_MAX_W-1:0] ann_chan(
    input logic [ANN_MAX_FLAT-1:0] flat,
    input int unsigned             width,
    input int unsigned             idx
  );
    logic [ANN_MAX_FLAT-1:0] sh;
    logic [ANN_MAX_W-1:0]    mask;
    sh   = flat >> (idx * width);
    mask = (width >= ANN_MAX_W) ? '1 : ((ANN_MAX_W'(1) << width) - ANN_MAX_W'(1));
    return sh[ANN_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/ann_mul.sv
// Combinational WIDTH x WIDTH multiplier keeping only the low WIDTH bits.
module ann_mul #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/ann_neuron_seq.sv
// Sequential neuron y = s*w_out + s, s = sum x[i]*w[i], one shared multiplier.
// Optional ANN_RELU_EN: negative results are clamped to zero before registering.
module ann_neuron_seq
  import ann_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 2,
  localparam int CNT_W = $clog2(N_IN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] x_flat,
  input  logic [N_IN*WIDTH-1:0] w_flat,
  input  logic [WIDTH-1:0]      w_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      y,
  output logic                  busy
);

  ann_state_t            r_state;
  logic [N_IN*WIDTH-1:0] r_x;
  logic [N_IN*WIDTH-1:0] r_w;
  logic [WIDTH-1:0]      r_wout;
  logic [WIDTH-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_y;
  logic                  r_out_valid;

  logic [WIDTH-1:0]      w_x_ch;
  logic [WIDTH-1:0]      w_w_ch;
  logic [WIDTH-1:0]      w_mul_a;
  logic [WIDTH-1:0]      w_mul_b;
  logic [WIDTH-1:0]      w_prod;
  logic [WIDTH-1:0]      w_sum;
  logic [WIDTH-1:0]      w_res;

  assign w_x_ch = WIDTH'(ann_chan(ANN_MAX_FLAT'(r_x), WIDTH, 32'(r_cnt)));
  assign w_w_ch = WIDTH'(ann_chan(ANN_MAX_FLAT'(r_w), WIDTH, 32'(r_cnt)));

  always_comb begin
    w_mul_a = w_x_ch;
    w_mul_b = w_w_ch;
    if (r_state == ST_SCALE) begin
      w_mul_a = r_acc;
      w_mul_b = r_wout;
    end
  end

  ann_mul #(.WIDTH(WIDTH)) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // One adder serves both stages: acc + x*w in MAC, acc*w_out + acc in SCALE.
  assign w_sum = r_acc + w_prod;

  always_comb begin
    w_res = w_sum;
`ifdef ANN_RELU_EN
    if (w_sum[WIDTH-1]) w_res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_w         <= '0;
      r_wout      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x     <= x_flat;
            r_w     <= w_flat;
            r_wout  <= w_out;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N_IN - 1)) r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_y         <= w_res;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule

// File: tb/tb_ann_neuron_seq.sv
// Bench for ann_neuron_seq: N_IN=2, 4 and 1 instances checked against an arithmetic model.
module tb_ann_neuron_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    in_valid;
  logic [W-1:0]  w_out_d;
  logic          out_ready;
  logic [2*W-1:0] x2, wf2;
  logic [4*W-1:0] x4, wf4;
  logic [W-1:0]   x1, wf1;
  logic [2:0]    ir, ov, bz;
  logic [W-1:0]  y2, y4, y1;

  ann_neuron_seq #(.WIDTH(W), .N_IN(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(ir[0]),
    .x_flat(x2), .w_flat(wf2), .w_out(w_out_d), .out_valid(ov[0]),
    .out_ready(out_ready), .y(y2), .busy(bz[0]));

  ann_neuron_seq #(.WIDTH(W), .N_IN(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(ir[1]),
    .x_flat(x4), .w_flat(wf4), .w_out(w_out_d), .out_valid(ov[1]),
    .out_ready(out_ready), .y(y4), .busy(bz[1]));

  ann_neuron_seq #(.WIDTH(W), .N_IN(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(ir[2]),
    .x_flat(x1), .w_flat(wf1), .w_out(w_out_d), .out_valid(ov[2]),
    .out_ready(out_ready), .y(y1), .busy(bz[2]));

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ta_x [4];
  logic [W-1:0] ta_w [4];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] yv(input int sel);
    return (sel == 0) ? y2 : (sel == 1) ? y4 : y1;
  endfunction

  function automatic int n_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 4 : 1;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] wo, input int n);
    logic [W-1:0] s;
    logic [W-1:0] r;
    s = '0;
    for (int i = 0; i < n; i++) s = s + ta_x[i] * ta_w[i];
    r = s * wo + s;
`ifdef ANN_RELU_EN
    if (r[W-1]) r = '0;
`endif
    return r;
  endfunction

  task automatic scramble();
    x4 = {$urandom, $urandom, $urandom, $urandom};
    wf4 = {$urandom, $urandom, $urandom, $urandom};
    x2 = x4[2*W-1:0];
    wf2 = wf4[2*W-1:0];
    x1 = x4[W-1:0];
    wf1 = wf4[W-1:0];
    w_out_d = $urandom;
  endtask

  task automatic load();
    x4  = {ta_x[3], ta_x[2], ta_x[1], ta_x[0]};
    wf4 = {ta_w[3], ta_w[2], ta_w[1], ta_w[0]};
    x2  = {ta_x[1], ta_x[0]};
    wf2 = {ta_w[1], ta_w[0]};
    x1  = ta_x[0];
    wf1 = ta_w[0];
  endtask

  // One full transaction on instance sel; stall = cycles of out_ready=0 after out_valid.
  task automatic run_op(input string tag, input int sel, input logic [W-1:0] wo,
                        input logic [W-1:0] exp, input int stall);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(ir[sel]), 32'd1);
    load();
    w_out_d = wo;
    out_ready = (stall == 0);
    in_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    in_valid = '0;
    scramble();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk({tag, "_busy"}, 32'(bz[sel]), 32'd1);
        chk({tag, "_in_ready_busy"}, 32'(ir[sel]), 32'd0);
      end
    end while (!ov[sel] && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(n_of(sel) + 2));
    chk({tag, "_y"}, yv(sel), exp);
    for (int k = 0; k < stall; k++) begin
      in_valid[sel] = (k == 1);
      if (k == 1) scramble();
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(ov[sel]), 32'd1);
      chk({tag, "_hold_y"}, yv(sel), exp);
    end
    in_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(ov[sel]), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(ir[sel]), 32'd1);
    chk({tag, "_idle"}, 32'(bz[sel]), 32'd0);
    if (stall > 0) begin
      @(negedge clk);
      chk({tag, "_single_pulse"}, 32'(ov[sel]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    scramble();

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_out_valid", 32'(ov[s]), 32'd0);
      chk("rst_y", yv(s), 32'd0);
      chk("rst_busy", 32'(bz[s]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk("rst_in_ready", 32'(ir[s]), 32'd1);

    ta_x = '{32'd3, 32'd5, 32'd0, 32'd0};
    ta_w = '{32'd2, 32'd4, 32'd0, 32'd0};
    run_op("basic", 0, 32'd10, 32'd286, 0);

    ta_x = '{32'h0001_0000, 32'd1, 32'd0, 32'd0};
    ta_w = '{32'h0001_0000, 32'd7, 32'd0, 32'd0};
    run_op("wrap", 0, 32'd1, 32'd14, 0);

    ta_x = '{32'd1, 32'd0, 32'd0, 32'd0};
    ta_w = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
`ifdef ANN_RELU_EN
    run_op("neg", 0, 32'd1, 32'd0, 0);
`else
    run_op("neg", 0, 32'd1, 32'hFFFF_FFFE, 0);
`endif

    ta_x = '{32'd3, 32'd5, 32'd0, 32'd0};
    ta_w = '{32'd2, 32'd4, 32'd0, 32'd0};
    run_op("stall", 0, 32'd10, 32'd286, 5);

    // Abort in cycle T+2; y still holds 286 from the previous transaction.
    @(negedge clk);
    ta_x = '{32'd9, 32'd9, 32'd0, 32'd0};
    ta_w = '{32'd9, 32'd9, 32'd0, 32'd0};
    load();
    w_out_d = 32'd3;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(ov[0]), 32'd0);
    chk("abort_y", y2, 32'd0);
    chk("abort_busy", 32'(bz[0]), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_output", 32'(ov[0]), 32'd0);
    ta_x = '{32'd1, 32'd1, 32'd0, 32'd0};
    ta_w = '{32'd1, 32'd1, 32'd0, 32'd0};
    run_op("after_abort", 0, 32'd0, 32'd2, 0);

    ta_x = '{32'd1, 32'd2, 32'd3, 32'd4};
    ta_w = '{32'd1, 32'd1, 32'd1, 32'd1};
    run_op("n4", 1, 32'd2, 32'd30, 0);

    ta_x = '{32'd7, 32'd0, 32'd0, 32'd0};
    ta_w = '{32'd6, 32'd0, 32'd0, 32'd0};
    run_op("n1", 2, 32'd2, 32'd126, 0);

    for (int it = 0; it < 12; it++) begin
      int sel;
      int stall;
      logic [W-1:0] wo;
      sel = $urandom_range(0, 2);
      stall = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        ta_x[i] = $urandom;
        ta_w[i] = (it < 4) ? W'($urandom_range(0, 50)) : $urandom;
      end
      wo = $urandom;
      run_op("rand", sel, wo, model(wo, n_of(sel)), stall);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
